// File: rtl/lfsr_crypt_pkg.sv
// Shared types and address-map defaults for the LFSR encryption DMA engine.
package lfsr_crypt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_TAP,
    READ,
    WRITE,
    DONE
  } state_e;

  // Data-memory layout defaults
  localparam logic [7:0] DEF_TAP_BASE = 8'd130;
  localparam int unsigned DEF_NUM_TAPS = 9;
  localparam logic [7:0] DEF_SRC_BASE = 8'd0;
  localparam logic [7:0] DEF_DST_BASE = 8'd64;

  // Longest message the engine will process
  localparam logic [6:0] MAX_LEN = 7'd64;

  // Character codes used by the CPU-side software that prepares the buffers
  localparam logic [7:0] SPACE_CHAR = 8'h20;
  localparam logic [7:0] DELIM_CHAR = 8'h00;

endpackage

// File: rtl/lfsr_crypt_dma_if.sv
// Single-port data-memory bus: one address, combinational read, clocked write.
interface lfsr_crypt_dma_if;
  logic [7:0] DataAddress;
  logic       WriteEn;
  logic [7:0] DataOut;
  logic [7:0] DataIn;

  modport master (output DataAddress, output WriteEn, output DataOut, input DataIn);
  modport slave  (input DataAddress, input WriteEn, input DataOut, output DataIn);
endinterface

// File: rtl/lfsr_crypt_dma_lfsr7.sv
// 7-bit Fibonacci-style LFSR with loadable seed and runtime tap mask.
module lfsr7 (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       load,
  input  logic [6:0] seed,
  input  logic       step,
  input  logic [6:0] taps,
  output logic [6:0] state
);

  // Load has priority over step; feedback is the parity of the tapped bits
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= 7'd0;
    end else if (load) begin
      state <= seed;
    end else if (step) begin
      state <= {state[5:0], ^(state & taps)};
    end
  end

endmodule

// File: rtl/lfsr_crypt_dma.sv
// Memory-master engine: fetches a tap pattern, then XOR-encrypts Len source
// bytes with a running LFSR keystream into the destination region.
module lfsr_crypt_dma
  import lfsr_crypt_pkg::*;
#(
  parameter logic [7:0]  TAP_BASE = DEF_TAP_BASE,
  parameter int unsigned NUM_TAPS = DEF_NUM_TAPS,
  parameter logic [7:0]  SRC_BASE = DEF_SRC_BASE,
  parameter logic [7:0]  DST_BASE = DEF_DST_BASE
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic [3:0]              TapSel,
  input  logic [6:0]              Seed,
  input  logic [6:0]              Len,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Error,
  lfsr_crypt_dma_if.master        mem
);

  state_e     state;
  logic [3:0] tapsel_q;
  logic [6:0] seed_q;
  logic [6:0] len_q;
  logic [6:0] taps_q;
  logic [7:0] byte_q;
  logic [6:0] idx_q;
  logic       err_q;
  logic [6:0] lfsr;

  lfsr7 u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (state == LOAD_TAP),
    .seed  (seed_q),
    .step  (state == WRITE),
    .taps  (taps_q),
    .state (lfsr)
  );

  // Control FSM plus the captured request, tap mask, byte register and index
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      tapsel_q <= 4'd0;
      seed_q   <= 7'd0;
      len_q    <= 7'd0;
      taps_q   <= 7'd0;
      byte_q   <= 8'd0;
      idx_q    <= 7'd0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            tapsel_q <= TapSel;
            seed_q   <= Seed;
            len_q    <= (Len > MAX_LEN) ? MAX_LEN : Len;
            err_q    <= 1'b0;
            if (32'(TapSel) >= NUM_TAPS) begin
              err_q <= 1'b1;
              state <= DONE;
            end else if (Len == 7'd0) begin
              state <= DONE;
            end else begin
              state <= LOAD_TAP;
            end
          end
        end
        LOAD_TAP: begin
          taps_q <= mem.DataIn[6:0];
          idx_q  <= 7'd0;
          state  <= READ;
        end
        READ: begin
          byte_q <= mem.DataIn;
          state  <= WRITE;
        end
        WRITE: begin
          idx_q <= idx_q + 7'd1;
          state <= (idx_q + 7'd1 == len_q) ? DONE : READ;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Moore decode of the bus; an async reset forces IDLE and so kills WriteEn at once
  always_comb begin
    mem.DataAddress = 8'd0;
    mem.WriteEn     = 1'b0;
    mem.DataOut     = 8'd0;
    case (state)
      LOAD_TAP: mem.DataAddress = TAP_BASE + {4'd0, tapsel_q};
      READ:     mem.DataAddress = SRC_BASE + {1'b0, idx_q};
      WRITE: begin
        mem.DataAddress = DST_BASE + {1'b0, idx_q};
        mem.WriteEn     = 1'b1;
        mem.DataOut     = byte_q ^ {1'b0, lfsr};
      end
      default: ;
    endcase
  end

  assign Busy  = (state != IDLE);
  assign Done  = (state == DONE);
  assign Error = err_q;

endmodule

// File: tb/tb_lfsr_crypt_dma.sv
// Directed bench for lfsr_crypt_dma with a write scoreboard and memory model.
module tb_lfsr_crypt_dma;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [3:0] TapSel;
  logic [6:0] Seed;
  logic [6:0] Len;
  logic       Busy;
  logic       Done;
  logic       Error;

  lfsr_crypt_dma_if bus ();

  lfsr_crypt_dma dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Start  (Start),
    .TapSel (TapSel),
    .Seed   (Seed),
    .Len    (Len),
    .Busy   (Busy),
    .Done   (Done),
    .Error  (Error),
    .mem    (bus)
  );

  always #5 Clk = ~Clk;

  // Data memory: combinational read, clocked write, bench preload port
  logic [7:0] mem [256];
  logic       pl_en;
  logic [7:0] pl_addr;
  logic [7:0] pl_data;

  assign bus.DataIn = mem[bus.DataAddress];

  always @(posedge Clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.WriteEn) mem[bus.DataAddress] <= bus.DataOut;
  end

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every presented write must match the next expected one
  always @(negedge Clk) begin
    if (bus.WriteEn === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%0h data=%0h required none",
                 bus.DataAddress, bus.DataOut);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("write_addr", 32'(bus.DataAddress), 32'(e[15:8]));
        check("write_data", 32'(bus.DataOut), 32'(e[7:0]));
      end
    end
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge Clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge Clk);
    pl_en = 1'b0;
  endtask

  task automatic expect_wr(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  // Drive Start for edge 0, then scramble the request inputs to prove capture
  task automatic start_op(input logic [3:0] ts, input logic [6:0] sd, input logic [6:0] ln);
    @(negedge Clk);
    TapSel = ts; Seed = sd; Len = ln; Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0; TapSel = 4'hF; Seed = 7'h55; Len = 7'd7;
    check("busy_cycle1", 32'(Busy), 32'd1);
  endtask

  // Count cycles from 1 until Done; optionally pulse Start during cycles 2..4
  task automatic wait_done(input int exp_cyc, input logic exp_err, input logic pulse);
    int cyc;
    cyc = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge Clk);
      if (Done === 1'b1) begin
        cyc = c;
        break;
      end
      Start = pulse && (c >= 2) && (c <= 4);
    end
    Start = 1'b0;
    check("done_cycle", 32'(cyc), 32'(exp_cyc));
    check("error_at_done", 32'(Error), 32'(exp_err));
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; TapSel = 4'd0; Seed = 7'd0; Len = 7'd0;
    pl_en = 1'b0; pl_addr = 8'd0; pl_data = 8'd0;
    #1;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_error", 32'(Error), 32'd0);
    check("rst_we", 32'(bus.WriteEn), 32'd0);
    check("rst_addr", 32'(bus.DataAddress), 32'd0);
    check("rst_dout", 32'(bus.DataOut), 32'd0);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;

    // Basic two-byte encryption with taps 0x60
    poke(8'd130, 8'h60);
    poke(8'd131, 8'h41);
    poke(8'd0, 8'h41);
    poke(8'd1, 8'h42);
    expect_wr(8'd64, 8'h40);
    expect_wr(8'd65, 8'h40);
    start_op(4'd0, 7'h01, 7'd2);
    wait_done(6, 1'b0, 1'b0);

    // All-ones seed, single byte
    poke(8'd0, 8'h20);
    expect_wr(8'd64, 8'h5F);
    start_op(4'd0, 7'h7F, 7'd1);
    wait_done(4, 1'b0, 1'b0);

    // Out-of-range tap index: error, immediate Done, no access
    start_op(4'd9, 7'h01, 7'd1);
    wait_done(1, 1'b1, 1'b0);
    @(negedge Clk);
    check("err_idle_busy", 32'(Busy), 32'd0);
    check("err_held", 32'(Error), 32'd1);

    // Zero length: Busy pulses one cycle, Error cleared by the new Start
    start_op(4'd0, 7'h01, 7'd0);
    wait_done(1, 1'b0, 1'b0);
    @(negedge Clk);
    check("len0_busy_drop", 32'(Busy), 32'd0);

    // Seed 0 copies plaintext; Start pulses while busy are ignored
    poke(8'd0, 8'h11);
    poke(8'd1, 8'h22);
    poke(8'd2, 8'h33);
    poke(8'd3, 8'h44);
    expect_wr(8'd64, 8'h11);
    expect_wr(8'd65, 8'h22);
    expect_wr(8'd66, 8'h33);
    expect_wr(8'd67, 8'h44);
    start_op(4'd0, 7'h00, 7'd4);
    wait_done(10, 1'b0, 1'b1);

    // Reset during the write of byte 3 of 10
    for (int k = 0; k < 10; k++) begin
      poke(8'(k), 8'hA0 + 8'(k));
      poke(8'd64 + 8'(k), 8'hEE);
    end
    for (int k = 0; k < 4; k++) expect_wr(8'd64 + 8'(k), 8'hA0 + 8'(k));
    start_op(4'd0, 7'h00, 7'd10);
    repeat (9) @(negedge Clk);
    check("pre_rst_we", 32'(bus.WriteEn), 32'd1);
    check("pre_rst_addr", 32'(bus.DataAddress), 32'd67);
    #2;
    Reset = 1'b0;
    #1;
    check("mid_rst_we", 32'(bus.WriteEn), 32'd0);
    check("mid_rst_addr", 32'(bus.DataAddress), 32'd0);
    check("mid_rst_dout", 32'(bus.DataOut), 32'd0);
    check("mid_rst_busy", 32'(Busy), 32'd0);
    check("mid_rst_done", 32'(Done), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    for (int k = 0; k < 10; k++)
      check("partial_dst", 32'(mem[8'd64 + 8'(k)]), (k < 3) ? 32'hA0 + 32'(k) : 32'hEE);

    // Full transfer after reset, tap index 1 with nonzero feedback
    poke(8'd0, 8'h00);
    poke(8'd1, 8'h00);
    poke(8'd2, 8'h00);
    expect_wr(8'd64, 8'h40);
    expect_wr(8'd65, 8'h01);
    expect_wr(8'd66, 8'h03);
    start_op(4'd1, 7'h40, 7'd3);
    wait_done(8, 1'b0, 1'b0);

    // Length above 64 truncates to 64 bytes
    for (int k = 0; k < 64; k++) begin
      poke(8'(k), 8'(k) ^ 8'h5A);
      expect_wr(8'd64 + 8'(k), 8'(k) ^ 8'h5A);
    end
    start_op(4'd0, 7'h00, 7'd100);
    wait_done(130, 1'b0, 1'b0);

    @(negedge Clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_crypt_dma.md
# lfsr_crypt_dma

Memory-side initiator that drives the single-port data memory (one address pointer, combinational read, write on clock edge) to LFSR-encrypt a message buffer in place-to-place. On Start it fetches a 7-bit tap pattern from the tap-pattern list in data memory, then streams Len bytes from the source region. Each byte is XORed with the running 7-bit LFSR state and written to the destination region. It sits beside the CPU as a memory master, sharing the data-memory port when the CPU is stalled.

## Interface
- TAP_BASE, 130: data-memory address of tap pattern 0.
- NUM_TAPS, 9: number of valid tap patterns.
- SRC_BASE, 0: first source (plaintext) address.
- DST_BASE, 64: first destination (ciphertext) address.
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  request pulse; sampled only in IDLE.
- TapSel  in  4  tap-pattern index, captured at Start.
- Seed  in  7  initial LFSR state, captured at Start.
- Len  in  7  byte count 0..64, captured at Start.
- Busy  out  1  high from the cycle after Start until DONE is left.
- Done  out  1  one-cycle completion pulse.
- Error  out  1  TapSel ≥ NUM_TAPS at Start; held until the next accepted Start.
- DataAddress  out  8  memory address.
- WriteEn  out  1  memory write strobe.
- DataOut  out  8  write data to memory DataIn.
- DataIn  in  8  read data from memory DataOut, valid in the same cycle as DataAddress.

## Operation
- FSM states: IDLE, LOAD_TAP, READ, WRITE, DONE.
- IDLE:
  - Start=1 captures TapSel, Seed and Len, and clears Error.
  - TapSel ≥ NUM_TAPS: set Error, go to DONE, perform no memory access.
  - Len=0: go to DONE, perform no access.
  - Otherwise go to LOAD_TAP.
- LOAD_TAP:
  - DataAddress=TAP_BASE+TapSel.
  - Latch DataIn[6:0] as taps at the edge.
  - LFSR ← Seed, i ← 0, go to READ.
- READ:
  - DataAddress=SRC_BASE+i.
  - Latch DataIn into the byte register at the edge, go to WRITE.
- WRITE:
  - DataAddress=DST_BASE+i, WriteEn=1, DataOut=byte ^ {1'b0, LFSR}.
  - At the edge: LFSR ← {LFSR[5:0], ^(LFSR & taps)} and i ← i+1.
  - If i+1==Len go to DONE, else go to READ.
- DONE: Done=1 for one cycle, then go to IDLE.
- Address arithmetic is 8-bit and wraps modulo 256; no range checking.
- Seed=0 is legal. The LFSR stays at 0 and ciphertext equals plaintext.
- Start outside IDLE is ignored. TapSel, Seed and Len changes outside IDLE are ignored.
- Len values > 64 are truncated to 64.
- SRC and DST regions may overlap. Each byte is always read before its own write.

## Timing
- All outputs are Moore outputs decoded from registered state, registered byte and LFSR, and i.
- Reset (async, asserted low):
  - State=IDLE.
  - Busy=0, Done=0, Error=0, WriteEn=0, DataAddress=0, DataOut=0.
  - Asserting Reset mid-transfer drops WriteEn immediately. The current write must not complete.
- In IDLE, DataAddress=0, WriteEn=0 and DataOut=0.
- Start is sampled at edge 0.
  - LOAD_TAP occupies cycle 1.
  - READ/WRITE pairs occupy cycles 2..2·Len+1.
  - Done is high in cycle 2·Len+2.
- Error or Len=0: Done is high in cycle 1.
- Back-to-back operation: a Start in the cycle after Done is accepted. Throughput is one byte per 2 cycles.
- WriteEn is never high outside WRITE.

## Structure
- Package lfsr_crypt_pkg holds:
  - the state enum;
  - TAP_BASE, NUM_TAPS, SRC_BASE and DST_BASE defaults;
  - SPACE_CHAR=8'h20 and DELIM_CHAR=8'h00 for the CPU-side software.
- Sub-module lfsr7:
  - inputs: load, seed[6:0], step, taps[6:0];
  - output: state[6:0].
  - Async active-low reset to 0.

## Test plan
- Memory[130]=8'h60, [0]=8'h41, [1]=8'h42; TapSel=0, Seed=7'h01, Len=2.
  - Expect writes [64]=8'h40 and [65]=8'h40.
  - Expect Done in cycle 6, Error=0.
- TapSel=0, Seed=7'h7F, Len=1, [0]=8'h20 → [64]=8'h5F, Done in cycle 4.
- TapSel=9 → Error=1 and Done in cycle 1, no WriteEn. A following valid Start clears Error.
- Len=0 → Done in cycle 1, zero writes, Busy pulses for one cycle.
- Assert Reset during the WRITE of byte 3 of 10:
  - WriteEn=0 immediately and all outputs are 0.
  - Bytes 0–2 remain written, bytes 3 and later remain unchanged.
  - A new Start after release runs a full transfer correctly.
- Seed=0, Len=4 → destination equals source. Start pulses while Busy are ignored.
